// File: rtl/ultrasonido_scheduler.sv
// Round-robin HC-SR04 sequencer: fires trigger, times echo with timeout, converts to cm.
// Define ULTRA_SCHED_STATS_EN to add the o_timeout_count statistics port.
module ultrasonido_scheduler #(
    parameter int unsigned N_CH            = 4,
    parameter int unsigned TICK_CYC        = 50,
    parameter int unsigned TRIG_CYC        = 500,
    parameter int unsigned CM_DIV          = 58,
    parameter int unsigned ECHO_TIMEOUT_US = 30000,
    parameter int unsigned GUARD_US        = 60000
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            i_enable,
    input  logic [N_CH-1:0] i_ch_mask,
    input  logic [15:0]     i_threshold_cm,
    input  logic [N_CH-1:0] i_echo,
    output logic [N_CH-1:0] o_trigger,
    output logic            o_result_valid,
    input  logic            i_result_ready,
    output logic [2:0]      o_result_ch,
    output logic [15:0]     o_result_cm,
    output logic            o_result_timeout,
    output logic [N_CH-1:0] o_near,
    output logic            o_busy
`ifdef ULTRA_SCHED_STATS_EN
    ,
    output logic [15:0]     o_timeout_count
`endif
);

    localparam int unsigned CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned PRESC_W = $clog2(TICK_CYC + 1);
    localparam int unsigned TRIG_W  = $clog2(TRIG_CYC + 1);
    localparam int unsigned DIV_W   = $clog2(CM_DIV + 1);
    localparam int unsigned US_MAX  = (ECHO_TIMEOUT_US > GUARD_US) ? ECHO_TIMEOUT_US : GUARD_US;
    localparam int unsigned US_W    = $clog2(US_MAX + 1);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_CYC - 1);
    localparam logic [TRIG_W-1:0]  TRIG_LAST  = TRIG_W'(TRIG_CYC - 1);
    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CM_DIV - 1);
    localparam logic [US_W-1:0]    TO_LAST    = US_W'(ECHO_TIMEOUT_US - 1);
    localparam logic [US_W-1:0]    GUARD_LAST = US_W'(GUARD_US - 1);
    localparam logic [CH_W-1:0]    CH_LAST    = CH_W'(N_CH - 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SELECT    = 3'd1;
    localparam logic [2:0] ST_TRIG      = 3'd2;
    localparam logic [2:0] ST_WAIT_ECHO = 3'd3;
    localparam logic [2:0] ST_MEASURE   = 3'd4;
    localparam logic [2:0] ST_RESULT    = 3'd5;
    localparam logic [2:0] ST_GUARD     = 3'd6;

    logic [2:0]         r_state;
    logic [N_CH-1:0]    r_echo_meta;
    logic [N_CH-1:0]    r_echo_sync;
    logic [PRESC_W-1:0] r_presc;
    logic [US_W-1:0]    r_us;
    logic [TRIG_W-1:0]  r_trig_cnt;
    logic [CH_W-1:0]    r_cur_ch;
    logic [CH_W-1:0]    r_last_ch;
    logic [15:0]        r_cm;
    logic [DIV_W-1:0]   r_div;
    logic [2:0]         r_res_ch;
    logic [15:0]        r_res_cm;
    logic               r_res_timeout;
    logic [N_CH-1:0]    r_near;

    logic [2:0]         w_state_next;
    logic               w_state_change;
    logic               w_timeout_hit;
    logic               w_tick;
    logic               w_echo_s;
    logic               w_hs;
    logic               w_found;
    logic [CH_W-1:0]    w_next_ch;
    logic [CH_W-1:0]    w_cand;
    logic [15:0]        w_cm_next;
    logic [DIV_W-1:0]   w_div_next;

    assign w_tick   = (r_presc == PRESC_LAST);
    assign w_echo_s = r_echo_sync[r_cur_ch];
    assign w_hs     = (r_state == ST_RESULT) && i_result_ready;

    // Search starts one past the last served channel so every enabled channel gets a turn.
    always_comb begin
        w_found   = 1'b0;
        w_next_ch = r_last_ch;
        w_cand    = r_last_ch;
        for (int i = 0; i < N_CH; i++) begin
            w_cand = (w_cand == CH_LAST) ? '0 : w_cand + CH_W'(1);
            if (!w_found && i_ch_mask[w_cand]) begin
                w_found   = 1'b1;
                w_next_ch = w_cand;
            end
        end
    end

    always_comb begin
        w_cm_next  = r_cm;
        w_div_next = r_div;
        if (w_tick) begin
            if (r_div == DIV_LAST) begin
                w_div_next = '0;
                if (r_cm != 16'hFFFE) begin
                    w_cm_next = r_cm + 16'd1;
                end
            end else begin
                w_div_next = r_div + DIV_W'(1);
            end
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_timeout_hit = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_enable && (|i_ch_mask)) w_state_next = ST_SELECT;
            end
            ST_SELECT: w_state_next = w_found ? ST_TRIG : ST_IDLE;
            ST_TRIG: begin
                if (r_trig_cnt == TRIG_LAST) w_state_next = ST_WAIT_ECHO;
            end
            ST_WAIT_ECHO: begin
                if (w_echo_s) begin
                    w_state_next = ST_MEASURE;
                end else if (w_tick && (r_us == TO_LAST)) begin
                    w_state_next  = ST_RESULT;
                    w_timeout_hit = 1'b1;
                end
            end
            ST_MEASURE: begin
                if (!w_echo_s) begin
                    w_state_next = ST_RESULT;
                end else if (w_tick && (r_us == TO_LAST)) begin
                    w_state_next  = ST_RESULT;
                    w_timeout_hit = 1'b1;
                end
            end
            ST_RESULT: begin
                if (i_result_ready) w_state_next = ST_GUARD;
            end
            ST_GUARD: begin
                if (w_tick && (r_us == GUARD_LAST)) begin
                    w_state_next = (i_enable && (|i_ch_mask)) ? ST_SELECT : ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_state_change = (w_state_next != r_state);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_echo_meta   <= '0;
            r_echo_sync   <= '0;
            r_presc       <= '0;
            r_us          <= '0;
            r_trig_cnt    <= '0;
            r_cur_ch      <= '0;
            r_last_ch     <= CH_LAST;
            r_cm          <= '0;
            r_div         <= '0;
            r_res_ch      <= '0;
            r_res_cm      <= '0;
            r_res_timeout <= 1'b0;
            r_near        <= '0;
        end else begin
            r_echo_meta <= i_echo;
            r_echo_sync <= r_echo_meta;
            r_state     <= w_state_next;
            // Prescaler and counters restart on every state entry.
            if (w_state_change) begin
                r_presc    <= '0;
                r_us       <= '0;
                r_trig_cnt <= '0;
            end else begin
                r_presc <= w_tick ? '0 : r_presc + PRESC_W'(1);
                if (w_tick) r_us <= r_us + US_W'(1);
                if (r_state == ST_TRIG) r_trig_cnt <= r_trig_cnt + TRIG_W'(1);
            end
            if ((r_state == ST_SELECT) && w_found) r_cur_ch <= w_next_ch;
            if (r_state == ST_MEASURE) begin
                r_cm  <= w_cm_next;
                r_div <= w_div_next;
            end else begin
                r_cm  <= '0;
                r_div <= '0;
            end
            if ((w_state_next == ST_RESULT) && (r_state != ST_RESULT)) begin
                r_res_ch      <= 3'(r_cur_ch);
                r_res_cm      <= w_timeout_hit ? 16'hFFFF : w_cm_next;
                r_res_timeout <= w_timeout_hit;
            end
            if (w_hs) begin
                r_last_ch        <= r_cur_ch;
                r_near[r_cur_ch] <= !r_res_timeout && (r_res_cm < i_threshold_cm);
            end
        end
    end

`ifdef ULTRA_SCHED_STATS_EN
    logic [15:0] r_timeout_count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_timeout_count <= '0;
        end else if (w_hs && r_res_timeout && (r_timeout_count != 16'hFFFF)) begin
            r_timeout_count <= r_timeout_count + 16'd1;
        end
    end

    assign o_timeout_count = r_timeout_count;
`endif

    assign o_trigger        = (r_state == ST_TRIG) ? (N_CH'(1) << r_cur_ch) : '0;
    assign o_result_valid   = (r_state == ST_RESULT);
    assign o_result_ch      = r_res_ch;
    assign o_result_cm      = r_res_cm;
    assign o_result_timeout = r_res_timeout;
    assign o_near           = r_near;
    assign o_busy           = (r_state != ST_IDLE);

endmodule
